// File: rtl/ifetch.sv
// ----------------------------------------------------------------------------
// ifetch: instruction fetch stage sitting directly in front of decode.
//
// Reads one INST_WIDTH instruction from byte-wide instruction memory, one
// M_WIDTH beat at a time, low byte first. The beats are collected in a shadow
// register. When the last beat arrives, the assembled word and its PC are
// registered onto inst/pc and ready pulses for one cycle. The block also owns
// the program counter: it increments sequentially, and the execute stage can
// redirect it through pc_load/pc_next for jumps and branches.
//
// Optional feature, off by default:
//   IFETCH_ALIGN_CHECK_EN - when defined, a fetch request at a PC that is not
//   instruction-aligned skips memory and raises a one-cycle fault pulse in
//   place of ready. When undefined, fault is tied low and a misaligned PC
//   simply fetches the next BEATS consecutive bytes.
// ----------------------------------------------------------------------------
module ifetch #(
    parameter int M_WIDTH    = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_next,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [M_WIDTH-1:0]    mem_data,
    input  logic                  mem_ack,
    output logic [INST_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  ready,
    output logic                  busy,
    output logic                  fault
);

    // Number of memory beats that make up one instruction.
    localparam int BEATS  = INST_WIDTH / M_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP   = ADDR_WIDTH'(BEATS);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [BEAT_W-1:0]     BEAT_ONE  = BEAT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   pc_reg;       // architectural PC: next instruction to fetch
    logic [BEAT_W-1:0]       beat;         // index of the beat currently being read
    logic [INST_WIDTH-1:0]   shadow;       // partially assembled instruction
    logic [INST_WIDTH-1:0]   shadow_next;  // shadow with the current beat merged in
    logic [ADDR_WIDTH-1:0]   fetch_pc;     // PC a fetch started this cycle would use
    logic                    align_fault;  // fetch request rejected as misaligned
    logic                    start_fetch;  // accepted fetch request in IDLE

    // Fetch address: a redirect in the same cycle as en takes effect first.
    always_comb begin
        fetch_pc = pc_load ? pc_next : pc_reg;
    end

`ifdef IFETCH_ALIGN_CHECK_EN
    // Reject requests whose PC is not aligned to a whole instruction.
    always_comb begin
        align_fault = en && (fetch_pc[BEAT_W-1:0] != '0);
    end
`else
    // Without the alignment check, every request is accepted.
    always_comb begin
        align_fault = 1'b0;
    end
`endif

    // A request only starts a memory fetch when it passes the alignment check.
    always_comb begin
        start_fetch = en && !align_fault;
    end

    // Merge the incoming memory byte into its slot of the instruction word.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
        shadow_next = shadow;
        for (int i = 0; i < BEATS; i++) begin
            if (beat == BEAT_W'(i)) begin
                shadow_next[i*M_WIDTH +: M_WIDTH] = mem_data;
            end
        end
    end

    // Fetch FSM: owns the PC, issues the beats, and publishes inst/pc/ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the shadow register is cleared on reset as well, so no stale data is ever observable.
            state    <= S_IDLE;
            pc_reg   <= RESET_PC;
            beat     <= '0;
            mem_addr <= RESET_PC;
            mem_rd   <= 1'b0;
            shadow   <= '0;
            inst     <= '0;
            pc       <= RESET_PC;
            ready    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only; ready defaults low so it is a single-cycle pulse.
            ready <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (pc_load) begin
                        pc_reg <= pc_next;
                    end
                    if (start_fetch) begin
                        state    <= S_FETCH;
                        beat     <= '0;
                        mem_addr <= fetch_pc;
                        mem_rd   <= 1'b1;
                        busy     <= 1'b1;
                    end
                end

                S_FETCH: begin
                    if (pc_load) begin
                        // Redirect aborts the fetch. Any beat acked this cycle is dropped.
                        state  <= S_IDLE;
                        mem_rd <= 1'b0;
                        busy   <= 1'b0;
                        pc_reg <= pc_next;
                    end else if (mem_ack) begin
                        shadow <= shadow_next;
                        if (beat == LAST_BEAT) begin
                            // Last beat: publish the word. ready is visible during the DONE cycle.
                            state  <= S_DONE;
                            mem_rd <= 1'b0;
                            inst   <= shadow_next;
                            pc     <= pc_reg;
                            ready  <= 1'b1;
                        end else begin
                            beat     <= beat + BEAT_ONE;
                            mem_addr <= mem_addr + ADDR_ONE;
                        end
                    end
                end

                S_DONE: begin
                    // The ready pulse is already on the outputs during this cycle.
                    // A redirect arriving now still wins over the sequential increment.
                    state  <= S_IDLE;
                    busy   <= 1'b0;
                    pc_reg <= pc_load ? pc_next : pc_reg + PC_STEP;
                end

                default: begin
                    state  <= S_IDLE;
                    mem_rd <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

`ifdef IFETCH_ALIGN_CHECK_EN
    // One-cycle fault pulse for a misaligned request seen in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault <= 1'b0;
        end else begin
            fault <= (state == S_IDLE) && align_fault;
        end
    end
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch.sv
// ----------------------------------------------------------------------------
// tb_ifetch: self-checking bench for ifetch.
// A byte memory with a configurable wait count answers read beats. A
// transaction-level model tracks the PC and the last published instruction,
// and expected words are assembled straight from the memory array.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        pc_load;
    logic [7:0]  pc_next;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data;
    logic        mem_ack;
    logic [31:0] inst;
    logic [7:0]  pc;
    logic        ready;
    logic        busy;
    logic        fault;

    ifetch #(
        .M_WIDTH(8),
        .ADDR_WIDTH(8),
        .INST_WIDTH(32),
        .RESET_PC(8'h00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .pc_load(pc_load),
        .pc_next(pc_next),
        .mem_addr(mem_addr),
        .mem_rd(mem_rd),
        .mem_data(mem_data),
        .mem_ack(mem_ack),
        .inst(inst),
        .pc(pc),
        .ready(ready),
        .busy(busy),
        .fault(fault)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    int wait_cfg  = 0;
    int wait_left = 0;
    int n_tests   = 0;
    int n_fail    = 0;

    // Reference state: next PC to fetch, and the last published instruction.
    logic [7:0]  model_pc;
    logic [31:0] model_inst;
    logic [7:0]  model_ipc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Move to the sampling point of the next cycle, well away from the clock edges.
    task automatic step();
        @(negedge clk);
        #2;
    endtask

    // Expected instruction word at byte address a, low byte first, with address wrap.
    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return {mem[8'(a + 3)], mem[8'(a + 2)], mem[8'(a + 1)], mem[a]};
    endfunction

    function automatic logic [7:0] rand_tgt();
        logic [7:0] t;
        t = 8'($urandom);
`ifdef IFETCH_ALIGN_CHECK_EN
        t = t & 8'hFC;
`endif
        return t;
    endfunction

    // Memory responder: each beat is acked after wait_cfg idle cycles.
    initial begin
        mem_ack  = 1'b0;
        mem_data = 8'h00;
        forever begin
            @(negedge clk);
            if (rst || !mem_rd) begin
                mem_ack   = 1'b0;
                mem_data  = 8'($urandom);
                wait_left = wait_cfg;
            end else if (wait_left == 0) begin
                mem_ack   = 1'b1;
                mem_data  = mem[mem_addr];
                wait_left = wait_cfg;
            end else begin
                mem_ack   = 1'b0;
                mem_data  = 8'($urandom);
                wait_left--;
            end
        end
    end

    // One fetch request. An optional redirect is given together with en.
    // If abort_cyc is nonzero, a redirect to abort_tgt is issued in that cycle of the fetch.
    task automatic do_fetch(input bit redir, input logic [7:0] tgt, input int w,
                            input int abort_cyc, input logic [7:0] abort_tgt);
        logic [7:0] fpc;
        int cyc;
        int beats;
        int exp_lat;
        wait_cfg = w;
        step();
        en      = 1'b1;
        pc_load = redir;
        pc_next = tgt;
        fpc     = redir ? tgt : model_pc;
        exp_lat = 4 * (w + 1) + 1;
        beats   = 0;
        step();
        en      = 1'b0;
        pc_load = 1'b0;
        cyc     = 1;
        while (1) begin
            if (ready) break;
            if (cyc > exp_lat + 20) begin
                check("ready_timeout", ready, 1'b1);
                return;
            end
            check("rd_held", mem_rd, 1'b1);
            if (mem_rd && mem_ack) begin
                check("beat_addr", mem_addr, 8'(fpc + beats));
                beats++;
            end
            if (cyc == abort_cyc) begin
                pc_load = 1'b1;
                pc_next = abort_tgt;
                step();
                pc_load = 1'b0;
                check("abort_rd", mem_rd, 1'b0);
                check("abort_busy", busy, 1'b0);
                model_pc = abort_tgt;
                for (int i = 0; i < 6; i++) begin
                    check("abort_noready", ready, 1'b0);
                    check("abort_inst", inst, model_inst);
                    check("abort_pc", pc, model_ipc);
                    step();
                end
                return;
            end
            step();
            cyc++;
        end
        check("latency", cyc, exp_lat);
        check("beats", beats, 4);
        check("inst", inst, mem_word(fpc));
        check("pc", pc, fpc);
        check("busy_done", busy, 1'b1);
        model_inst = mem_word(fpc);
        model_ipc  = fpc;
        model_pc   = 8'(fpc + 4);
        step();
        check("ready_pulse", ready, 1'b0);
        check("busy_idle", busy, 1'b0);
        check("inst_stable", inst, model_inst);
    endtask

    initial begin
        int rcount;
        int r1;
        int r2;
        logic [7:0] p0;
        rst     = 1'b1;
        en      = 1'b0;
        pc_load = 1'b0;
        pc_next = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
        model_pc = 8'h00; model_inst = 32'h0; model_ipc = 8'h00;
        #1;
        check("rst_addr", mem_addr, 8'h00);
        check("rst_rd", mem_rd, 1'b0);
        check("rst_inst", inst, 32'h0);
        check("rst_pc", pc, 8'h00);
        check("rst_ready", ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_fault", fault, 1'b0);
        step(); step();
        rst = 1'b0;
        step();

        // Zero-wait fetch at reset PC.
        do_fetch(1'b0, 8'h00, 0, 0, 8'h00);
        check("inst_known", inst, 32'h00100513);
        // Same fetch with two wait cycles per beat.
        do_fetch(1'b1, 8'h00, 2, 0, 8'h00);
        check("inst_known_wait", inst, 32'h00100513);
        // Redirect together with en.
        do_fetch(1'b1, 8'h40, 0, 0, 8'h00);
        // Sequential fetch from 0x44, aborted in its second beat.
        do_fetch(1'b0, 8'h00, 0, 2, 8'h80);
        // Fetch from the abort target, then top-of-memory wrap.
        do_fetch(1'b0, 8'h00, 1, 0, 8'h00);
        do_fetch(1'b1, 8'hFC, 0, 0, 8'h00);
        check("pc_wrap", model_pc, 8'h00);
        do_fetch(1'b0, 8'h00, 0, 0, 8'h00);

`ifdef IFETCH_ALIGN_CHECK_EN
        // Misaligned request: fault pulse, no memory access, PC kept.
        step();
        pc_load = 1'b1; pc_next = 8'h42;
        step();
        pc_load = 1'b0; en = 1'b1;
        step();
        en = 1'b0;
        check("align_fault", fault, 1'b1);
        check("align_rd", mem_rd, 1'b0);
        check("align_inst", inst, model_inst);
        step();
        check("align_fault_pulse", fault, 1'b0);
        check("align_rd2", mem_rd, 1'b0);
        model_pc = 8'h42;
        do_fetch(1'b1, 8'h10, 0, 0, 8'h00);
`else
        // Misaligned fetch reads consecutive bytes.
        do_fetch(1'b1, 8'h42, 0, 0, 8'h00);
        check("fault_tied", fault, 1'b0);
`endif

        // Back-to-back fetches with en held high: one word per 6 cycles.
        wait_cfg = 0;
        step();
        p0 = model_pc;
        en = 1'b1;
        rcount = 0; r1 = 0; r2 = 0;
        for (int c = 1; c <= 11; c++) begin
            step();
            if (ready) begin
                rcount++;
                if (rcount == 1) begin
                    r1 = c;
                    check("b2b_inst1", inst, mem_word(p0));
                end else begin
                    r2 = c;
                    check("b2b_inst2", inst, mem_word(8'(p0 + 4)));
                end
            end
            if (c == 11) en = 1'b0;
        end
        check("b2b_count", rcount, 2);
        check("b2b_first", r1, 5);
        check("b2b_second", r2, 11);
        model_inst = mem_word(8'(p0 + 4));
        model_ipc  = 8'(p0 + 4);
        model_pc   = 8'(p0 + 8);
        step();
        check("b2b_idle", busy, 1'b0);
        do_fetch(1'b0, 8'h00, 0, 0, 8'h00);

        // Reset in the middle of a fetch.
        wait_cfg = 1;
        step();
        en = 1'b1;
        step();
        en = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("midrst_rd", mem_rd, 1'b0);
        check("midrst_addr", mem_addr, 8'h00);
        check("midrst_inst", inst, 32'h0);
        check("midrst_pc", pc, 8'h00);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ready", ready, 1'b0);
        model_pc = 8'h00; model_inst = 32'h0; model_ipc = 8'h00;
        step();
        rst = 1'b0;
        step();
        do_fetch(1'b0, 8'h00, 0, 0, 8'h00);

        // Randomized fetches with random redirects, waits and aborts.
        for (int it = 0; it < 40; it++) begin
            bit rd;
            int w;
            int ab;
            rd = ($urandom_range(0, 2) == 0);
            w  = $urandom_range(0, 3);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4 * (w + 1)) : 0;
            do_fetch(rd, rand_tgt(), w, ab, rand_tgt());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
